// File: rtl/fsk_rx_pkg.sv
// Shared definitions for the FSK receiver: framer states, widths and the default sync pattern.
package fsk_rx_pkg;

  localparam int PAYLOAD_W = 16;
  localparam int SYNC_W    = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 8'hD5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } framer_state_t;

endpackage

// File: rtl/fsk_edge_counter.sv
// Synchronises the FSK tone, counts rising edges per symbol window and classifies each window.
module fsk_edge_counter #(
  parameter int SYMBOL_CYCLES = 12000,
  parameter int EDGE_THRESH   = 1250,
  parameter int MIN_EDGES     = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic rf_in,
  output logic sym_bit,
  output logic sym_valid,
  output logic carrier,
  output logic win_end
);

  localparam int WW = $clog2(SYMBOL_CYCLES);
  localparam int EW = $clog2(SYMBOL_CYCLES + 1);
  localparam logic [WW-1:0] W_LAST = WW'(SYMBOL_CYCLES - 1);
  localparam logic [EW-1:0] THRESH = EW'(EDGE_THRESH);
  localparam logic [EW-1:0] MIN_N  = EW'(MIN_EDGES);

  logic [2:0]    sync_q;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] edge_cnt;
  logic          rise;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] is history for edge detection
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      win_cnt   <= '0;
      edge_cnt  <= '0;
      sym_bit   <= 1'b0;
      sym_valid <= 1'b0;
      carrier   <= 1'b0;
      win_end   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], rf_in};
      sym_valid <= 1'b0;
      win_end   <= 1'b0;
      if (win_cnt == W_LAST) begin
        win_cnt   <= '0;
        // an edge landing on the wrap cycle belongs to the new window
        edge_cnt  <= rise ? EW'(1) : '0;
        sym_bit   <= (edge_cnt >= THRESH);
        carrier   <= (edge_cnt >= MIN_N);
        sym_valid <= (edge_cnt >= MIN_N);
        win_end   <= 1'b1;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        if (rise && (edge_cnt != '1))
          edge_cnt <= edge_cnt + EW'(1);
      end
    end
  end

endmodule

// File: rtl/fsk_demod_rx.sv
// FSK receiver top: edge-count demodulator plus sync-word framer for 16-bit payloads.
// Defining FSK_RX_ERRCNT_EN adds err_cnt, a saturating count of aborted frames.
module fsk_demod_rx
  import fsk_rx_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 12000,
  parameter int EDGE_THRESH   = 1250,
  parameter int MIN_EDGES     = 500,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rf_in,
  output logic                 sym_bit,
  output logic                 sym_valid,
  output logic                 carrier,
  output logic                 locked,
  output logic [PAYLOAD_W-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err
`ifdef FSK_RX_ERRCNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  // state   | meaning
  // HUNT    | shifting symbols, looking for SYNC_WORD
  // RECEIVE | collecting PAYLOAD_W payload symbols
  // DONE    | one cycle: publish payload, back to HUNT

  localparam int BW = $clog2(PAYLOAD_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_W - 1);

  framer_state_t        state;
  logic                 win_end;
  logic [SYNC_W-1:0]    sync_reg;
  logic [SYNC_W-1:0]    sync_shift;
  logic [PAYLOAD_W-1:0] payload;
  logic [BW-1:0]        bit_cnt;

  fsk_edge_counter #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES),
    .EDGE_THRESH  (EDGE_THRESH),
    .MIN_EDGES    (MIN_EDGES)
  ) u_edge (
    .clk      (clk),
    .reset    (reset),
    .rf_in    (rf_in),
    .sym_bit  (sym_bit),
    .sym_valid(sym_valid),
    .carrier  (carrier),
    .win_end  (win_end)
  );

  assign sync_shift = {sync_reg[SYNC_W-2:0], sym_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      sync_reg   <= '0;
      payload    <= '0;
      bit_cnt    <= '0;
      locked     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FSK_RX_ERRCNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        HUNT: begin
          if (win_end && !carrier) begin
            sync_reg <= '0;
          end else if (sym_valid) begin
            sync_reg <= sync_shift;
            if (sync_shift == SYNC_WORD) begin
              state   <= RECEIVE;
              bit_cnt <= '0;
              locked  <= 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (win_end && !carrier) begin
            state     <= HUNT;
            locked    <= 1'b0;
            sync_reg  <= '0;
            payload   <= '0;
            frame_err <= 1'b1;
`ifdef FSK_RX_ERRCNT_EN
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
`endif
          end else if (sym_valid) begin
            payload <= {payload[PAYLOAD_W-2:0], sym_bit};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state  <= DONE;
              locked <= 1'b0;
            end
          end
        end
        DONE: begin
          data       <= payload;
          data_valid <= 1'b1;
          sync_reg   <= '0;
          state      <= HUNT;
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_demod_rx.sv
// Scoreboard bench for fsk_demod_rx with a scaled-down symbol window (96 clk).
module tb_fsk_demod_rx;

  localparam int SC = 96;
  localparam int ET = 10;
  localparam int ME = 4;
  localparam logic [31:0] SYNC = 32'hD5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rf_in = 1'b0;
  logic        sym_bit, sym_valid, carrier, locked, data_valid, frame_err;
  logic [15:0] data;
`ifdef FSK_RX_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  fsk_demod_rx #(
    .SYMBOL_CYCLES(SC),
    .EDGE_THRESH  (ET),
    .MIN_EDGES    (ME),
    .SYNC_WORD    (8'hD5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rf_in     (rf_in),
    .sym_bit   (sym_bit),
    .sym_valid (sym_valid),
    .carrier   (carrier),
    .locked    (locked),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err)
`ifdef FSK_RX_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          sym_q[$];
  logic [15:0] data_q[$];
  int          ferr_seen = 0;
  int          ferr_exp = 0;
  int          hcnt = 0;
  int          cyc = 0;
  int          last_sv = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // kind 1: toggle every 4 clk, kind 0: every 6 clk, kind 2: silent
  task automatic drive(input int kind, input int n);
    int half;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kind == 2) begin
        rf_in = 1'b0;
      end else begin
        half = (kind == 1) ? 4 : 6;
        if (hcnt >= half - 1) begin
          hcnt  = 0;
          rf_in = ~rf_in;
        end else begin
          hcnt++;
        end
      end
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    bit b;
    for (int i = n - 1; i >= 0; i--) begin
      b = v[i];
      sym_q.push_back(b);
      drive(b ? 1 : 0, SC);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sym_bit"}, sym_bit, 0);
    chk({tag, "_sym_valid"}, sym_valid, 0);
    chk({tag, "_carrier"}, carrier, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_data"}, data, 16'h0000);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
`ifdef FSK_RX_ERRCNT_EN
    chk({tag, "_err_cnt"}, err_cnt, 8'd0);
`endif
  endtask

  always @(posedge clk) cyc++;

  // monitor: pops expectations whenever the DUT presents a symbol or a payload
  always @(negedge clk) begin
    bit          eb;
    logic [15:0] ed;
    if (reset) begin
      last_sv = -1;
    end else begin
      if (sym_valid) begin
        if (sym_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sym_unexpected: got sym_valid with bit %0b, expected no symbol", sym_bit);
        end else begin
          eb = sym_q.pop_front();
          chk("sym_bit", sym_bit, eb);
        end
        chk("sym_carrier", carrier, 1);
        if (last_sv >= 0) chk("sym_period", (cyc - last_sv) % SC, 0);
        last_sv = cyc;
      end
      if (data_valid) begin
        if (data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_unexpected: got data_valid with %0h, expected none", data);
        end else begin
          ed = data_q.pop_front();
          chk("data", data, ed);
        end
      end
      if (frame_err) ferr_seen++;
    end
  end

  initial begin
    reset = 1'b1;
    drive(2, 5);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // high tone twice, low tone twice, then a silent window
    send_bits(32'b1100, 4);
    drive(2, SC);
    drive(2, 10);
    chk("no_carrier", carrier, 0);
    drive(2, SC - 10);

    // idle symbols 0,1 then sync D5 then payload A53C
    data_q.push_back(16'hA53C);
    send_bits(32'b01, 2);
    send_bits(SYNC >> 1, 7);
    sym_q.push_back(1'b1);
    drive(1, 10);
    chk("locked_before_sync_end", locked, 0);
    drive(1, SC - 10);
    sym_q.push_back(1'b1);
    drive(1, 10);
    chk("locked_after_sync", locked, 1);
    drive(1, SC - 10);
    send_bits(32'h253C, 15);
    drive(2, 10);
    chk("data_a53c", data, 16'hA53C);
    chk("locked_after_frame", locked, 0);
    drive(2, SC - 10);

    // carrier loss after 7 payload symbols
    send_bits(SYNC, 8);
    send_bits(32'h55, 7);
    drive(2, SC);
    ferr_exp++;
    drive(2, 10);
    chk("frame_err_count", ferr_seen, ferr_exp);
    chk("locked_after_abort", locked, 0);
    chk("data_held", data, 16'hA53C);
`ifdef FSK_RX_ERRCNT_EN
    chk("err_cnt_one", err_cnt, 8'd1);
`endif
    drive(2, SC - 10);

    // back-to-back frames, first payload ends in the sync pattern
    data_q.push_back(16'h00D5);
    data_q.push_back(16'h1234);
    send_bits(SYNC, 8);
    send_bits(32'h00D5, 16);
    send_bits(SYNC, 8);
    send_bits(32'h1234, 16);
    drive(2, 10);
    chk("data_1234", data, 16'h1234);
    drive(2, SC - 10);

    // reset during payload bit 9
    send_bits(SYNC, 8);
    send_bits(32'h187, 9);
    sym_q.push_back(1'b1);
    drive(1, 40);
    reset = 1'b1;
    drive(2, 3);
    void'(sym_q.pop_back());
    chk_reset_outputs("midreset");
    chk("midreset_no_frame_err", ferr_seen, ferr_exp);
    reset = 1'b0;
    hcnt = 0;

    // recovery after reset
    data_q.push_back(16'h5A0F);
    send_bits(SYNC, 8);
    send_bits(32'h5A0F, 16);
    drive(2, 20);
    chk("data_5a0f", data, 16'h5A0F);
    chk("final_frame_err_count", ferr_seen, ferr_exp);
    chk("sym_queue_empty", sym_q.size(), 0);
    chk("data_queue_empty", data_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
